// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the arbitrated register bank.
package reg_bank_pkg;

  localparam int DEF_REG_W    = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int LOCK_BIT     = DEF_REG_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// SPI peripheral port plus two local master request/response ports of the register bank.
interface reg_bank_arbiter_if import reg_bank_pkg::*; #(
  parameter int REG_W = DEF_REG_W
);

  logic [REG_W-2:0] spi_addr;
  logic             spi_we;
  logic [REG_W-1:0] spi_wdata;
  logic [REG_W-1:0] spi_rdata;

  logic             m0_req;
  logic             m0_wr;
  logic [REG_W-2:0] m0_addr;
  logic [REG_W-1:0] m0_wdata;
  logic             m0_gnt;
  logic             m0_rvalid;
  logic [REG_W-1:0] m0_rdata;

  logic             m1_req;
  logic             m1_wr;
  logic [REG_W-2:0] m1_addr;
  logic [REG_W-1:0] m1_wdata;
  logic             m1_gnt;
  logic             m1_rvalid;
  logic [REG_W-1:0] m1_rdata;

  modport master (
    output spi_addr, spi_we, spi_wdata,
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  spi_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  modport slave (
    input  spi_addr, spi_we, spi_wdata,
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output spi_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter; the pointer remembers who won last so a tie favours the other master.
module rr_arbiter (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ena,
  input  logic       update,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic lastM1_q, lastM1_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = lastM1_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    lastM1_d = lastM1_q;
    if (update && (grant != 2'b00)) begin
      lastM1_d = grant[1];
    end
  end

  // Reset as if m1 had just won, so m0 takes the first tie.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lastM1_q <= 1'b1;
    end else if (ena) begin
      lastM1_q <= lastM1_d;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by an SPI writer and two round-robin arbitrated local masters.
// Define REG_BANK_LOCK_EN to make bit REG_W-1 of register 0 a local-write lock for registers 1..N-1.
module reg_bank_arbiter import reg_bank_pkg::*; #(
  parameter int REG_W    = DEF_REG_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      ena,
  reg_bank_arbiter_if.slave         bus,
  output logic [NUM_REGS*REG_W-1:0] regs_o
);

  localparam int AW = REG_W - 1;

  state_e           state_q, state_d;
  logic             capM1_q, capM1_d;
  logic             capWr_q, capWr_d;
  logic [AW-1:0]    capAddr_q, capAddr_d;
  logic [REG_W-1:0] capWdata_q, capWdata_d;
  logic [REG_W-1:0] bank_q [NUM_REGS];
  logic [REG_W-1:0] bank_d [NUM_REGS];
  logic [REG_W-1:0] m0Rdata_q, m0Rdata_d;
  logic [REG_W-1:0] m1Rdata_q, m1Rdata_d;

  logic [1:0]       arbGrant;
  logic             arbUpdate;
  logic             localWe;
  logic             writeBlocked;
  logic             fire;
  logic             respond;
  logic [REG_W-1:0] spiRead;
  logic [REG_W-1:0] capRead;

  rr_arbiter u_rr (
    .clk    (clk),
    .rstb   (rstb),
    .ena    (ena),
    .update (arbUpdate),
    .req    ({bus.m1_req, bus.m0_req}),
    .grant  (arbGrant)
  );

  // Out-of-range addresses match no register and therefore read as zero.
  always_comb begin
    spiRead = '0;
    capRead = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.spi_addr == i[AW-1:0]) spiRead = bank_q[i];
      if (capAddr_q == i[AW-1:0])    capRead = bank_q[i];
    end
  end

`ifdef REG_BANK_LOCK_EN
  localparam int LockIdx = LOCK_BIT + (REG_W - DEF_REG_W);
  assign writeBlocked = bank_q[0][LockIdx] && (capAddr_q != '0);
`else
  assign writeBlocked = 1'b0;
`endif

  assign fire    = ena && (state_q == GRANT) && !bus.spi_we;
  assign respond = ena && (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    capM1_d    = capM1_q;
    capWr_d    = capWr_q;
    capAddr_d  = capAddr_q;
    capWdata_d = capWdata_q;
    m0Rdata_d  = m0Rdata_q;
    m1Rdata_d  = m1Rdata_q;
    arbUpdate  = 1'b0;
    localWe    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          arbUpdate  = 1'b1;
          capM1_d    = arbGrant[1];
          capWr_d    = arbGrant[1] ? bus.m1_wr    : bus.m0_wr;
          capAddr_d  = arbGrant[1] ? bus.m1_addr  : bus.m0_addr;
          capWdata_d = arbGrant[1] ? bus.m1_wdata : bus.m0_wdata;
          state_d    = GRANT;
        end
      end
      // An SPI write owns the bank this cycle; the local access simply retries.
      GRANT: begin
        if (!bus.spi_we) begin
          if (capWr_q) begin
            localWe = !writeBlocked;
            state_d = IDLE;
          end else begin
            if (capM1_q) m1Rdata_d = capRead;
            else         m0Rdata_d = capRead;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bank_d[i] = bank_q[i];
      if (bus.spi_we && (bus.spi_addr == i[AW-1:0])) begin
        bank_d[i] = bus.spi_wdata;
      end else if (localWe && (capAddr_q == i[AW-1:0])) begin
        bank_d[i] = capWdata_q;
      end
      regs_o[i*REG_W +: REG_W] = bank_q[i];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      capM1_q    <= 1'b0;
      capWr_q    <= 1'b0;
      capAddr_q  <= '0;
      capWdata_q <= '0;
      m0Rdata_q  <= '0;
      m1Rdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else if (ena) begin
      state_q    <= state_d;
      capM1_q    <= capM1_d;
      capWr_q    <= capWr_d;
      capAddr_q  <= capAddr_d;
      capWdata_q <= capWdata_d;
      m0Rdata_q  <= m0Rdata_d;
      m1Rdata_q  <= m1Rdata_d;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign bus.spi_rdata = spiRead;
  assign bus.m0_gnt    = fire && !capM1_q;
  assign bus.m1_gnt    = fire && capM1_q;
  assign bus.m0_rvalid = respond && !capM1_q;
  assign bus.m1_rvalid = respond && capM1_q;
  assign bus.m0_rdata  = m0Rdata_q;
  assign bus.m1_rdata  = m1Rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed scenarios plus random transactions against a transaction-level bank model.
module tb_reg_bank_arbiter;
  import reg_bank_pkg::*;

  localparam int REG_W    = 8;
  localparam int NUM_REGS = 8;
  localparam int AW       = REG_W - 1;

  logic                      clk = 1'b0;
  logic                      rstb;
  logic                      ena;
  logic [NUM_REGS*REG_W-1:0] regs;

  reg_bank_arbiter_if #(.REG_W(REG_W)) bus ();

  reg_bank_arbiter #(.REG_W(REG_W), .NUM_REGS(NUM_REGS)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .ena    (ena),
    .bus    (bus),
    .regs_o (regs)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: bank contents, per-master read data, and which master won the last arbitration.
  logic [REG_W-1:0] mBank [NUM_REGS];
  logic [REG_W-1:0] mRd   [2];
  int               lastWin;

  bit               reqOn   [2];
  bit               reqWr   [2];
  logic [AW-1:0]    reqAddr [2];
  logic [REG_W-1:0] reqData [2];

  function automatic void mReset();
    for (int i = 0; i < NUM_REGS; i++) mBank[i] = '0;
    mRd[0]  = '0;
    mRd[1]  = '0;
    lastWin = 1;
  endfunction

  function automatic logic [REG_W-1:0] mRead(int a);
    if (a < NUM_REGS) return mBank[a];
    return '0;
  endfunction

  function automatic void mSpiWr(int a, logic [REG_W-1:0] d);
    if (a < NUM_REGS) mBank[a] = d;
  endfunction

  function automatic void mLocalWr(int a, logic [REG_W-1:0] d);
    bit lk;
`ifdef REG_BANK_LOCK_EN
    lk = mBank[0][REG_W-1] && (a != 0);
`else
    lk = 1'b0;
`endif
    if ((a < NUM_REGS) && !lk) mBank[a] = d;
  endfunction

  function automatic logic [NUM_REGS*REG_W-1:0] mFlat();
    logic [NUM_REGS*REG_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*REG_W +: REG_W] = mBank[i];
    return f;
  endfunction

  task automatic driveReqs();
    bus.m0_req   = reqOn[0];
    bus.m0_wr    = reqWr[0];
    bus.m0_addr  = reqAddr[0];
    bus.m0_wdata = reqData[0];
    bus.m1_req   = reqOn[1];
    bus.m1_wr    = reqWr[1];
    bus.m1_addr  = reqAddr[1];
    bus.m1_wdata = reqData[1];
  endtask

  task automatic spiWrite(input int a, input logic [REG_W-1:0] d);
    @(negedge clk);
    driveReqs();
    bus.spi_we    = 1'b1;
    bus.spi_addr  = AW'(a);
    bus.spi_wdata = d;
    mSpiWr(a, d);
  endtask

  // One arbitrated transaction: capture cycle, 'conflicts' SPI-stalled cycles, grant, then response for reads.
  task automatic runTxn(input int conflicts, input int cA, input logic [REG_W-1:0] cD,
                        input bit extraSpi, input int rdA);
    int               w, nCyc, sa;
    bit               sw;
    logic [REG_W-1:0] sd;
    bit               expG, expR;
    logic [1:0]       g, rv, eg, er;
    w       = (reqOn[0] && reqOn[1]) ? 1 - lastWin : (reqOn[1] ? 1 : 0);
    lastWin = w;
    nCyc    = conflicts + 2 + (reqWr[w] ? 0 : 1);
    for (int c = 0; c < nCyc; c++) begin
      @(negedge clk);
      driveReqs();
      sw = 1'b0;
      sa = (rdA >= 0) ? rdA : int'($urandom_range(0, 11));
      sd = REG_W'($urandom);
      if (c >= 1 && c <= conflicts) begin
        sw = 1'b1;
        sa = cA;
        sd = cD;
      end else if (extraSpi && (c == 0 || (c == nCyc - 1 && !reqWr[w]))) begin
        sw = 1'($urandom_range(0, 1));
      end
      bus.spi_we    = sw;
      bus.spi_addr  = AW'(sa);
      bus.spi_wdata = sd;
      #1;
      expG = (c == conflicts + 1);
      expR = !reqWr[w] && (c == conflicts + 2);
      eg   = expG ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
      er   = expR ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
      g    = {bus.m1_gnt, bus.m0_gnt};
      rv   = {bus.m1_rvalid, bus.m0_rvalid};
      checks++;
      if (g !== eg) begin
        errors++;
        $display("[TB] FAIL txn_gnt cycle %0d winner m%0d: got %b want %b", c, w, g, eg);
      end
      checks++;
      if (rv !== er) begin
        errors++;
        $display("[TB] FAIL txn_rvalid cycle %0d winner m%0d: got %b want %b", c, w, rv, er);
      end
      checks++;
      if (bus.m0_rdata !== mRd[0] || bus.m1_rdata !== mRd[1]) begin
        errors++;
        $display("[TB] FAIL txn_rdata cycle %0d: got %h/%h want %h/%h",
                 c, bus.m0_rdata, bus.m1_rdata, mRd[0], mRd[1]);
      end
      checks++;
      if (bus.spi_rdata !== mRead(sa)) begin
        errors++;
        $display("[TB] FAIL spi_rdata addr %0d: got %h want %h", sa, bus.spi_rdata, mRead(sa));
      end
      checks++;
      if (regs !== mFlat()) begin
        errors++;
        $display("[TB] FAIL regs_o cycle %0d: got %h want %h", c, regs, mFlat());
      end
      if (sw) mSpiWr(sa, sd);
      if (expG) begin
        if (reqWr[w]) mLocalWr(int'(reqAddr[w]), reqData[w]);
        else          mRd[w] = mRead(int'(reqAddr[w]));
        reqOn[w] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    mReset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (regs !== '0 || bus.spi_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bank: got regs %h spi %h want 0", regs, bus.spi_rdata);
    end
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid} !== 4'b0 ||
        bus.m0_rdata !== '0 || bus.m1_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got gnt %b%b rv %b%b rdata %h/%h want all 0",
               bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata);
    end
    @(negedge clk);
    rstb = 1'b1;
  endtask

`ifdef REG_BANK_LOCK_EN
  task automatic test_lock();
    spiWrite(0, 8'h80);
    reqOn[0] = 1'b1; reqWr[0] = 1'b1; reqAddr[0] = 1; reqData[0] = 8'h55;
    runTxn(0, 0, '0, 1'b0, 1);
    @(negedge clk);
    driveReqs();
    bus.spi_we = 1'b0;
    #1;
    checks++;
    if (regs[15:8] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL lock_drop: got reg1 %h want 00", regs[15:8]);
    end
    spiWrite(1, 8'h55);
    @(negedge clk);
    driveReqs();
    bus.spi_we = 1'b0;
    #1;
    checks++;
    if (regs[15:8] !== 8'h55) begin
      errors++;
      $display("[TB] FAIL lock_spi: got reg1 %h want 55", regs[15:8]);
    end
    reqOn[0] = 1'b1; reqWr[0] = 1'b1; reqAddr[0] = 0; reqData[0] = 8'h00;
    runTxn(0, 0, '0, 1'b0, 0);
    @(negedge clk);
    driveReqs();
    bus.spi_we = 1'b0;
    #1;
    checks++;
    if (regs[7:0] !== 8'h00) begin
      errors++;
      $display("[TB] FAIL lock_reg0_local: got reg0 %h want 00", regs[7:0]);
    end
  endtask
`endif

  task automatic test_both_reads();
    spiWrite(3, 8'h3A);
    spiWrite(5, 8'h5C);
    for (int r = 0; r < 2; r++) begin
      reqOn[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[0] = 3;
      reqOn[1] = 1'b1; reqWr[1] = 1'b0; reqAddr[1] = 5;
      runTxn(0, 0, '0, 1'b0, -1);
      runTxn(0, 0, '0, 1'b0, -1);
    end
  endtask

  task automatic test_write_latency();
    reqOn[0] = 1'b1; reqWr[0] = 1'b1; reqAddr[0] = 3; reqData[0] = 8'hA5;
    runTxn(0, 0, '0, 1'b0, 3);
    @(negedge clk);
    driveReqs();
    bus.spi_we   = 1'b0;
    bus.spi_addr = 3;
    #1;
    checks++;
    if (regs[31:24] !== 8'hA5 || bus.spi_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL write_latency: got reg3 %h spi %h want a5", regs[31:24], bus.spi_rdata);
    end
  endtask

  task automatic test_spi_conflict();
    reqOn[1] = 1'b1; reqWr[1] = 1'b1; reqAddr[1] = 2; reqData[1] = 8'h3C;
    runTxn(1, 2, 8'h11, 1'b0, 2);
    @(negedge clk);
    driveReqs();
    bus.spi_we   = 1'b0;
    bus.spi_addr = 2;
    #1;
    checks++;
    if (regs[23:16] !== 8'h3C || bus.spi_rdata !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL spi_conflict_final: got reg2 %h spi %h want 3c", regs[23:16], bus.spi_rdata);
    end
  endtask

  task automatic test_out_of_range();
    reqOn[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[0] = 9;
    runTxn(0, 0, '0, 1'b0, 9);
    reqOn[1] = 1'b1; reqWr[1] = 1'b1; reqAddr[1] = 10; reqData[1] = 8'hFF;
    runTxn(0, 0, '0, 1'b0, -1);
    @(negedge clk);
    driveReqs();
    bus.spi_we = 1'b0;
    #1;
    checks++;
    if (bus.m0_rdata !== 8'h00 || regs !== mFlat()) begin
      errors++;
      $display("[TB] FAIL out_of_range: got rdata %h regs %h want 00 / %h", bus.m0_rdata, regs, mFlat());
    end
  endtask

  task automatic test_enable();
    reqOn[0] = 1'b1; reqWr[0] = 1'b1; reqAddr[0] = 4; reqData[0] = 8'h77;
    reqOn[1] = 1'b0;
    lastWin  = 0;
    @(negedge clk);
    driveReqs();
    ena = 1'b1;
    bus.spi_we = 1'b0;
    #1;
    checks++;
    if (bus.m0_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enable_capture_gnt: got %b want 0", bus.m0_gnt);
    end
    @(negedge clk);
    ena = 1'b0;
    bus.spi_we = 1'b1; bus.spi_addr = 5; bus.spi_wdata = 8'hEE;
    @(negedge clk);
    bus.spi_we = 1'b0;
    #1;
    checks++;
    if (bus.m0_gnt !== 1'b0 || regs !== mFlat()) begin
      errors++;
      $display("[TB] FAIL enable_hold: got gnt %b regs %h want 0 / %h", bus.m0_gnt, regs, mFlat());
    end
    @(negedge clk);
    ena = 1'b1;
    #1;
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL enable_resume_gnt: got %b want 1", bus.m0_gnt);
    end
    mLocalWr(4, 8'h77);
    reqOn[0] = 1'b0;
    @(negedge clk);
    driveReqs();
    #1;
    checks++;
    if (regs[39:32] !== 8'h77 || regs !== mFlat()) begin
      errors++;
      $display("[TB] FAIL enable_write: got regs %h want %h", regs, mFlat());
    end
  endtask

  task automatic test_abort();
    reqOn[0] = 1'b0; reqOn[1] = 1'b0;
    @(negedge clk);
    driveReqs();
    bus.spi_we = 1'b0;
    bus.m1_req = 1'b1; bus.m1_wr = 1'b1; bus.m1_addr = 6; bus.m1_wdata = 8'h99;
    #2;
    bus.m1_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      driveReqs();
      #1;
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00 || regs !== mFlat()) begin
        errors++;
        $display("[TB] FAIL abort: got gnt %b%b regs %h want 00 / %h",
                 bus.m1_gnt, bus.m0_gnt, regs, mFlat());
      end
    end
  endtask

  task automatic test_random();
    int pat;
    for (int r = 0; r < 40; r++) begin
      pat = int'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        reqOn[m]   = pat[m];
        reqWr[m]   = 1'($urandom_range(0, 1));
        reqAddr[m] = AW'($urandom_range(0, 11));
        reqData[m] = REG_W'($urandom);
      end
      while (reqOn[0] || reqOn[1]) begin
        runTxn(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
               int'($urandom_range(0, 11)), REG_W'($urandom), 1'b1, -1);
      end
    end
  endtask

  task automatic test_reset_mid();
    spiWrite(2, 8'h42);
    spiWrite(6, 8'h24);
    reqOn[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[0] = 2; reqOn[1] = 1'b0;
    @(negedge clk);
    driveReqs();
    bus.spi_we = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_gnt: got %b want 1", bus.m0_gnt);
    end
    reqOn[0] = 1'b0;
    @(negedge clk);
    driveReqs();
    rstb = 1'b0;
    #1;
    checks++;
    if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00 || regs !== '0 || bus.m0_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_abort: got rv %b%b regs %h rdata %h want 0",
               bus.m1_rvalid, bus.m0_rvalid, regs, bus.m0_rdata);
    end
    mReset();
    @(negedge clk);
    rstb = 1'b1;
    reqOn[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[0] = 2;
    reqOn[1] = 1'b1; reqWr[1] = 1'b0; reqAddr[1] = 6;
    runTxn(0, 0, '0, 1'b0, -1);
    runTxn(0, 0, '0, 1'b0, -1);
  endtask

  initial begin
    ena           = 1'b1;
    bus.spi_we    = 1'b0;
    bus.spi_addr  = '0;
    bus.spi_wdata = '0;
    for (int m = 0; m < 2; m++) begin
      reqOn[m]   = 1'b0;
      reqWr[m]   = 1'b0;
      reqAddr[m] = '0;
      reqData[m] = '0;
    end
    driveReqs();
    $display("[TB] start");
    test_reset();
`ifdef REG_BANK_LOCK_EN
    test_lock();
`endif
    test_both_reads();
    test_write_latency();
    test_spi_conflict();
    test_out_of_range();
    test_enable();
    test_abort();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have parameter REG_W, default 8, register and data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of bank registers (at most 2^(REG_W-1)).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rstb  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  global enable; when low, all sequential state holds.
REQ-006 spi_addr  input  REG_W-1  register address from the SPI peripheral.
REQ-007 spi_we  input  1  single-cycle write strobe from the SPI peripheral.
REQ-008 spi_wdata  input  REG_W  SPI write data.
REQ-009 spi_rdata  output  REG_W  combinational read of bank[spi_addr].
REQ-010 m0_req/m1_req  input  1  local master request, held high until grant.
REQ-011 m0_wr/m1_wr  input  1  1 = write, 0 = read.
REQ-012 m0_addr/m1_addr  input  REG_W-1  local address; m0_wdata/m1_wdata input REG_W.
REQ-013 m0_gnt/m1_gnt  output  1  one-cycle grant pulse.
REQ-014 m0_rvalid/m1_rvalid  output  1  one-cycle read-data-valid pulse; m0_rdata/m1_rdata output REG_W.
REQ-015 regs_o  output  NUM_REGS*REG_W  flattened bank contents, register 0 in the LSBs.

Function
REQ-016 SHALL implement an FSM with states IDLE, GRANT and RESP.
REQ-017 IDLE: if any mX_req is high, SHALL capture the winner's wr, addr and wdata and go to GRANT; otherwise stay.
REQ-018 Arbitration SHALL be round-robin; with both requests high, the master not granted last wins; a single request wins immediately.
REQ-019 GRANT with spi_we low: SHALL pulse mX_gnt and perform the access. A write commits that cycle and returns to IDLE; a read latches mX_rdata and goes to RESP.
REQ-020 GRANT with spi_we high: SHALL suppress gnt and the local access, stay in GRANT, and retry the next cycle; SPI writes are never stalled.
REQ-021 RESP: SHALL pulse mX_rvalid with rdata stable, then return to IDLE; mX_rdata holds until the next read by that master.
REQ-022 Latency: for a request seen in IDLE at cycle N, gnt SHALL occur at N+1 (absent conflict); rvalid SHALL occur at N+2.
REQ-023 spi_we SHALL write bank[spi_addr] on the same clock edge in any FSM state.
REQ-024 spi_rdata SHALL reflect bank contents combinationally, including a write committed on the previous edge.
REQ-025 Addresses >= NUM_REGS: writes SHALL be ignored and reads SHALL return 0; gnt and rvalid still pulse.
REQ-026 Requests SHALL be sampled only in IDLE; deasserting req before the capture aborts cleanly; after capture, the transaction completes regardless of req.
REQ-027 At most one gnt and at most one rvalid SHALL be high in any cycle.

Reset
REQ-028 On rstb low: bank all 0, FSM in IDLE, all gnt/rvalid/rdata outputs 0, round-robin pointer set so that m0 wins the first tie.
REQ-029 Reset asserted mid-transaction SHALL abort it with no partial write and no late gnt or rvalid.

Configuration
REQ-030 Macro REG_BANK_LOCK_EN defined: bit REG_W-1 of register 0 is a lock; while set, local writes to registers 1..NUM_REGS-1 are dropped (gnt still pulses), SPI writes are unaffected, and register 0 stays writable by all.
REQ-031 Macro REG_BANK_LOCK_EN undefined: no lock; that bit is an ordinary storage bit.

Structure
REQ-032 Package reg_bank_pkg SHALL hold the FSM state enum, default REG_W and NUM_REGS constants, and the LOCK_BIT index.
REQ-033 Two-way round-robin selection SHALL be a sub-module rr_arbiter (inputs: req[1:0], update, clk, rstb, ena; output: one-hot grant).

Verification
REQ-034 Write m0_wr=1, addr=3, wdata=0xA5 -> m0_gnt at N+1; regs_o[31:24]=0xA5 and spi_rdata=0xA5 with spi_addr=3.
REQ-035 m0 and m1 reads held simultaneously -> grants m0 then m1 alternately, with rvalid two cycles after each capture; never both in one cycle.
REQ-036 m1 write to addr 2 in GRANT while spi_we writes 0x11 to addr 2 -> gnt delayed one cycle; final reg2 = m1 data; SPI write visible on spi_rdata for one cycle.
REQ-037 m0 read at addr 9 with NUM_REGS=8 -> m0_gnt, then m0_rvalid with m0_rdata=0x00; bank unchanged.
REQ-038 With REG_BANK_LOCK_EN: SPI writes 0x80 to reg0, then m0 writes 0x55 to reg1 -> gnt pulses, reg1 stays 0; SPI writes 0x55 to reg1 -> reg1=0x55.
REQ-039 rstb pulsed low during RESP -> no rvalid, all registers 0, and the next tie grants m0.
